// File: rtl/risc_pkg.sv
// Shared encodings for the RISC control sequencer: opcodes, FSM states and
// opcode classes. Later pipeline/hazard logic imports the same constants.
package risc_pkg;

  // 6-bit opcode set (IR[31:26])
  localparam logic [5:0] OP_NOP   = 6'd0;
  localparam logic [5:0] OP_ADD   = 6'd1;
  localparam logic [5:0] OP_SUB   = 6'd2;
  localparam logic [5:0] OP_STORE = 6'd3;
  localparam logic [5:0] OP_LOAD  = 6'd4;
  localparam logic [5:0] OP_MOVE  = 6'd5;
  localparam logic [5:0] OP_SGE   = 6'd6;
  localparam logic [5:0] OP_SLE   = 6'd7;
  localparam logic [5:0] OP_SGT   = 6'd8;
  localparam logic [5:0] OP_SLT   = 6'd9;
  localparam logic [5:0] OP_SEQ   = 6'd10;
  localparam logic [5:0] OP_SNE   = 6'd11;
  localparam logic [5:0] OP_AND   = 6'd12;
  localparam logic [5:0] OP_OR    = 6'd13;
  localparam logic [5:0] OP_XOR   = 6'd14;
  localparam logic [5:0] OP_NOT   = 6'd15;
  localparam logic [5:0] OP_MOVEI = 6'd16;
  localparam logic [5:0] OP_SLI   = 6'd17;
  localparam logic [5:0] OP_SRI   = 6'd18;
  localparam logic [5:0] OP_ADDI  = 6'd19;
  localparam logic [5:0] OP_SUBI  = 6'd20;
  localparam logic [5:0] OP_JUMP  = 6'd21;
  localparam logic [5:0] OP_BRA   = 6'd22;
  localparam logic [5:0] OP_ADDF  = 6'd23;
  localparam logic [5:0] OP_MULF  = 6'd24;

  // FSM state encoding
  localparam logic [2:0] FETCH     = 3'd0;
  localparam logic [2:0] DECODE    = 3'd1;
  localparam logic [2:0] EXECUTE   = 3'd2;
  localparam logic [2:0] MEM       = 3'd3;
  localparam logic [2:0] FPU_WAIT  = 3'd4;
  localparam logic [2:0] WRITEBACK = 3'd5;

  // Opcode class encoding
  localparam logic [2:0] NOP_C = 3'd0;
  localparam logic [2:0] ALU_C = 3'd1;
  localparam logic [2:0] LD_C  = 3'd2;
  localparam logic [2:0] ST_C  = 3'd3;
  localparam logic [2:0] JMP_C = 3'd4;
  localparam logic [2:0] BRA_C = 3'd5;
  localparam logic [2:0] FPU_C = 3'd6;
  localparam logic [2:0] ILL_C = 3'd7;

endpackage

// File: rtl/risc_opclass_decode.sv
// Combinational opcode -> class decoder. Kept separate so hazard logic can
// reuse exactly the same classification as the control sequencer.
module risc_opclass_decode
  import risc_pkg::*;
(
  input  logic [5:0] opcode,
  output logic [2:0] op_class
);

  // Map each opcode to its class; anything above MULF is illegal
  always_comb begin
    op_class = ILL_C;
    case (opcode)
      OP_NOP:           op_class = NOP_C;
      OP_STORE:         op_class = ST_C;
      OP_LOAD:          op_class = LD_C;
      OP_JUMP:          op_class = JMP_C;
      OP_BRA:           op_class = BRA_C;
      OP_ADDF, OP_MULF: op_class = FPU_C;
      // remaining codes up to SUBI are ALU ops (0, 3, 4 matched above)
      default:          if (opcode <= OP_SUBI) op_class = ALU_C;
    endcase
  end

endmodule

// File: rtl/risc_ctrl_sequencer.sv
// Multi-cycle control FSM for the RISC core. Produces single-cycle strobes
// for the register file, data memory, FPU and PC, counts retired
// instructions and flags illegal opcodes / FPU timeouts (sticky err).
//
// Handshakes: fetch_req/fetch_ack and mem_req/mem_ack are valid/ready
// pairs -- the request is held high until the cycle in which the ack is
// seen, and the transfer happens in exactly that cycle. fpu_start is a
// one-cycle launch; fpu_done is sampled every FPU_WAIT cycle.
module risc_ctrl_sequencer #(
  parameter int RET_W       = 16,
  parameter int FPU_TIMEOUT = 64
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             run,
  output logic             fetch_req,
  input  logic             fetch_ack,
  output logic             ir_load,
  input  logic [5:0]       opcode,
  input  logic             cond_true,
  output logic             register_we,
  output logic             data_we,
  output logic             mem_req,
  input  logic             mem_ack,
  output logic             fpu_start,
  input  logic             fpu_done,
  output logic             pc_inc,
  output logic             pc_load,
  output logic [RET_W-1:0] retired,
  output logic             err
);
  import risc_pkg::*;

  // last FPU_WAIT timer value before abort
  localparam logic [7:0] TMO_LAST = 8'(FPU_TIMEOUT - 1);

  logic [2:0]       state_q, state_d;
  logic [2:0]       class_q, class_d;
  logic [7:0]       timer_q, timer_d;
  logic [RET_W-1:0] retired_q, retired_d;
  logic             err_q, err_d;
  logic             retire;
  logic             fetch_go;
  logic [2:0]       dec_class;

  risc_opclass_decode u_decode (
    .opcode   (opcode),
    .op_class (dec_class)
  );

  // fetch request is masked while reset is held so nothing is issued
  assign fetch_go = run & rst_n;

  // Next-state, strobe decode and counter/error updates
  always_comb begin
    state_d     = state_q;
    class_d     = class_q;
    timer_d     = timer_q;
    err_d       = err_q;
    retire      = 1'b0;
    fetch_req   = 1'b0;
    ir_load     = 1'b0;
    register_we = 1'b0;
    data_we     = 1'b0;
    mem_req     = 1'b0;
    fpu_start   = 1'b0;
    pc_inc      = 1'b0;
    pc_load     = 1'b0;
    case (state_q)
      FETCH: begin
        fetch_req = fetch_go;
        ir_load   = fetch_go & fetch_ack;
        if (fetch_go && fetch_ack) state_d = DECODE;
      end
      DECODE: begin
        class_d = dec_class;
        case (dec_class)
          NOP_C: begin
            pc_inc  = 1'b1;
            retire  = 1'b1;
            state_d = FETCH;
          end
          ALU_C:       state_d = EXECUTE;
          LD_C, ST_C:  state_d = MEM;
          JMP_C: begin
            pc_load = 1'b1;
            retire  = 1'b1;
            state_d = FETCH;
          end
          BRA_C: begin
            pc_load = cond_true;
            pc_inc  = ~cond_true;
            retire  = 1'b1;
            state_d = FETCH;
          end
          FPU_C: begin
            fpu_start = 1'b1;
            timer_d   = 8'd0;
            state_d   = FPU_WAIT;
          end
          default: begin
            err_d   = 1'b1;
            pc_inc  = 1'b1;
            state_d = FETCH;
          end
        endcase
      end
      EXECUTE: state_d = WRITEBACK;
      MEM: begin
        mem_req = 1'b1;
        data_we = (class_q == ST_C);
        if (mem_ack) begin
          if (class_q == ST_C) begin
            pc_inc  = 1'b1;
            retire  = 1'b1;
            state_d = FETCH;
          end else begin
            state_d = WRITEBACK;
          end
        end
      end
      FPU_WAIT: begin
        timer_d = timer_q + 8'd1;
        // a done arriving in the timeout cycle still completes normally
        if (fpu_done) begin
          state_d = WRITEBACK;
        end else if (timer_q == TMO_LAST) begin
          err_d   = 1'b1;
          pc_inc  = 1'b1;
          state_d = FETCH;
        end
      end
      WRITEBACK: begin
        register_we = 1'b1;
        pc_inc      = 1'b1;
        retire      = 1'b1;
        state_d     = FETCH;
      end
      default: state_d = FETCH;
    endcase
    retired_d = retire ? retired_q + 1'b1 : retired_q;
  end

  // State and bookkeeping registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= FETCH;
      class_q   <= NOP_C;
      timer_q   <= 8'd0;
      retired_q <= '0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      class_q   <= class_d;
      timer_q   <= timer_d;
      retired_q <= retired_d;
      err_q     <= err_d;
    end
  end

  assign retired = retired_q;
  assign err     = err_q;

endmodule
